// File: rtl/alu_result_buffer_if.sv
// -----------------------------------------------------------------------------
// alu_result_buffer_if
// Bundle of the valid/ready signals on both sides of the ALU result buffer.
//   in_valid / in_ready / in_y / in_op     : producer (ALU) side
//   out_valid / out_ready / out_y / out_op : consumer side
//   out_zero / out_neg / out_parity        : status flags of the head entry
// Modports:
//   slave  : the buffer's view (accepts results, presents the head entry)
//   master : the environment's view (drives results, consumes the head)
// -----------------------------------------------------------------------------
interface alu_result_buffer_if #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_y;
    logic [OPW-1:0]   in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [OPW-1:0]   out_op;
    logic             out_zero;
    logic             out_neg;
    logic             out_parity;

    modport slave (
        input  in_valid, in_y, in_op, out_ready,
        output in_ready, out_valid, out_y, out_op, out_zero, out_neg, out_parity
    );

    modport master (
        output in_valid, in_y, in_op, out_ready,
        input  in_ready, out_valid, out_y, out_op, out_zero, out_neg, out_parity
    );
endinterface

// File: rtl/alu_result_buffer.sv
// -----------------------------------------------------------------------------
// alu_result_buffer
// Registered output stage behind the 16-bit ALU logic units. Each accepted
// result is stored with its opcode tag and with zero/negative/parity flags
// computed at capture time, in a small in-order FIFO. Also counts (with
// wrap-around) the results handed downstream.
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst        : asynchronous active-high reset
//   clear      : synchronous flush of the FIFO (delivered count kept)
//   bus        : alu_result_buffer_if.slave, both handshake sides + flags
//   occupancy  : number of entries currently held
//   delivered  : number of results popped since reset, wraps to 0
// -----------------------------------------------------------------------------
module alu_result_buffer #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16,
    localparam int AW   = $clog2(DEPTH),
    localparam int OCCW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    alu_result_buffer_if.slave   bus,
    output logic [OCCW-1:0]      occupancy,
    output logic [CNTW-1:0]      delivered
);

    typedef struct packed {
        logic             parity;
        logic             neg;
        logic             zero;
        logic [OPW-1:0]   op;
        logic [WIDTH-1:0] y;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_PARTIAL,
        ST_FULL
    } state_t;

    localparam logic [OCCW-1:0] FULL_OCC = OCCW'(DEPTH);

    // Control state
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCCW-1:0] occ_q, occ_d;
    logic [CNTW-1:0] delivered_q, delivered_d;

    // Entry storage: no reset needed, every visible output is masked by
    // occupancy, so stale contents can never leak out.
    entry_t mem_q [DEPTH];
    entry_t wr_entry_d;
    entry_t head;

    state_t state;
    logic   in_ready;
    logic   out_valid;
    logic   push;
    logic   pop;

    // The buffer state is fully described by the occupancy count.
    always_comb begin
        state = ST_PARTIAL;
        if (occ_q == '0) begin
            state = ST_EMPTY;
        end else if (occ_q == FULL_OCC) begin
            state = ST_FULL;
        end
    end

    // Next-state logic
    always_comb begin
        in_ready    = (state != ST_FULL);
        out_valid   = (state != ST_EMPTY);
        // clear wins over any transfer in the same cycle
        push        = bus.in_valid & in_ready & ~clear;
        pop         = out_valid & bus.out_ready & ~clear;

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        delivered_d = delivered_q;

        wr_entry_d.y      = bus.in_y;
        wr_entry_d.op     = bus.in_op;
        wr_entry_d.zero   = (bus.in_y == '0);
        wr_entry_d.neg    = bus.in_y[WIDTH-1];
        wr_entry_d.parity = ^bus.in_y;

        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d    = rd_ptr_q + AW'(1);
                delivered_d = delivered_q + CNTW'(1);
            end
            if (push && !pop) begin
                occ_d = occ_q + OCCW'(1);
            end else if (pop && !push) begin
                occ_d = occ_q - OCCW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            delivered_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            delivered_q <= delivered_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_entry_d;
        end
    end

    // Head is read straight from registered storage; masking with out_valid
    // makes the outputs drop to zero as soon as reset or clear empties the FIFO.
    always_comb begin
        head = mem_q[rd_ptr_q];
        if (!out_valid) begin
            head = '0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_y      = head.y;
    assign bus.out_op     = head.op;
    assign bus.out_zero   = head.zero;
    assign bus.out_neg    = head.neg;
    assign bus.out_parity = head.parity;
    assign occupancy      = occ_q;
    assign delivered      = delivered_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// -----------------------------------------------------------------------------
// tb_alu_result_buffer
// Directed test of alu_result_buffer: reset values, single pass-through,
// fill/backpressure, drain order and flags, streaming push+pop, clear,
// asynchronous reset mid-burst, and delivered-counter wrap (on a second
// instance with a 4-bit counter).
// -----------------------------------------------------------------------------
module tb_alu_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic [1:0]  occ;
    logic [15:0] deliv;
    logic [1:0]  occ_w;
    logic [3:0]  deliv_w;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] exp_q [$];
    logic [15:0] r;

    always #5 clk = ~clk;

    alu_result_buffer_if #(.WIDTH(16), .OPW(3)) a_if ();
    alu_result_buffer_if #(.WIDTH(16), .OPW(3)) w_if ();

    alu_result_buffer #(.WIDTH(16), .OPW(3), .DEPTH(2), .CNTW(16)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .bus       (a_if),
        .occupancy (occ),
        .delivered (deliv)
    );

    alu_result_buffer #(.WIDTH(16), .OPW(3), .DEPTH(2), .CNTW(4)) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .bus       (w_if),
        .occupancy (occ_w),
        .delivered (deliv_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %h", tag, got);
        end
    endtask

    // Advance one rising edge, then sample just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        clear = 1'b0;
        a_if.in_valid  = 1'b0;
        a_if.in_y      = '0;
        a_if.in_op     = '0;
        a_if.out_ready = 1'b0;
        w_if.in_valid  = 1'b0;
        w_if.in_y      = '0;
        w_if.in_op     = '0;
        w_if.out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", a_if.out_valid, 0);
        check("rst_in_ready",  a_if.in_ready,  1);
        check("rst_occ",       occ,            0);
        check("rst_delivered", deliv,          0);
        check("rst_out_y",     a_if.out_y,     0);
        rst = 1'b0;
        step();

        // Single pass: zero result
        a_if.in_valid  = 1'b1;
        a_if.in_y      = 16'h0000;
        a_if.in_op     = 3'd1;
        a_if.out_ready = 1'b1;
        step();
        a_if.in_valid = 1'b0;
        check("sp_out_valid", a_if.out_valid,  1);
        check("sp_out_y",     a_if.out_y,      16'h0000);
        check("sp_out_op",    a_if.out_op,     1);
        check("sp_zero",      a_if.out_zero,   1);
        check("sp_neg",       a_if.out_neg,    0);
        check("sp_parity",    a_if.out_parity, 0);
        check("sp_occ",       occ,             1);
        step();
        check("sp_delivered", deliv,          1);
        check("sp_empty",     a_if.out_valid, 0);

        // Fill with backpressure
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_y      = 16'hFFFF;
        a_if.in_op     = 3'd2;
        step();
        a_if.in_y      = 16'h8000;
        a_if.in_op     = 3'd3;
        step();
        check("fill_occ",      occ,           2);
        check("fill_in_ready", a_if.in_ready, 0);
        a_if.in_y  = 16'h5555;
        a_if.in_op = 3'd4;
        step();
        a_if.in_valid = 1'b0;
        check("full_occ_hold", occ,             2);
        check("full_head_y",   a_if.out_y,      16'hFFFF);
        check("full_head_op",  a_if.out_op,     2);
        check("ffff_neg",      a_if.out_neg,    1);
        check("ffff_parity",   a_if.out_parity, 0);
        check("ffff_zero",     a_if.out_zero,   0);

        // Drain
        a_if.out_ready = 1'b1;
        step();
        check("drain_y",      a_if.out_y,      16'h8000);
        check("drain_op",     a_if.out_op,     3);
        check("8000_neg",     a_if.out_neg,    1);
        check("8000_parity",  a_if.out_parity, 1);
        check("drain_occ",    occ,             1);
        check("drain_deliv1", deliv,           2);
        step();
        check("drain_empty",  a_if.out_valid, 0);
        check("drain_occ0",   occ,            0);
        check("drain_deliv2", deliv,          3);
        check("drain_out_y0", a_if.out_y,     0);

        // Streaming: occupancy held at 1
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        r = 16'($urandom_range(0, 65535));
        a_if.in_y = r;
        exp_q.push_back(r);
        step();
        a_if.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = 16'($urandom_range(0, 65535));
            a_if.in_y  = r;
            a_if.in_op = 3'(i);
            check($sformatf("stream_y[%0d]", i), a_if.out_y, exp_q[0]);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(r);
            check($sformatf("stream_occ[%0d]", i), occ, 1);
        end
        a_if.in_valid = 1'b0;
        check("stream_last_y", a_if.out_y, exp_q[0]);
        step();
        void'(exp_q.pop_front());
        check("stream_deliv", deliv, 24);
        check("stream_occ0",  occ,   0);

        // Clear with two entries; pop request in the same cycle is suppressed
        a_if.out_ready = 1'b0;
        a_if.in_valid  = 1'b1;
        a_if.in_y      = 16'h1234;
        step();
        a_if.in_y      = 16'h4321;
        step();
        check("clr_pre_occ", occ, 2);
        clear          = 1'b1;
        a_if.out_ready = 1'b1;
        step();
        clear          = 1'b0;
        a_if.in_valid  = 1'b0;
        a_if.out_ready = 1'b0;
        check("clr_occ",       occ,            0);
        check("clr_out_valid", a_if.out_valid, 0);
        check("clr_out_y",     a_if.out_y,     0);
        check("clr_deliv",     deliv,          24);
        check("clr_in_ready",  a_if.in_ready,  1);

        // Asynchronous reset in the middle of a burst, no clock edge needed
        a_if.in_valid = 1'b1;
        a_if.in_y     = 16'hAAAA;
        step();
        a_if.in_y     = 16'hBBBB;
        step();
        a_if.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", a_if.out_valid, 0);
        check("arst_in_ready",  a_if.in_ready,  1);
        check("arst_occ",       occ,            0);
        check("arst_deliv",     deliv,          0);
        check("arst_out_y",     a_if.out_y,     0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Delivered counter wrap on the 4-bit instance
        w_if.in_valid  = 1'b1;
        w_if.out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            w_if.in_y = 16'(i);
            step();
        end
        check("wrap_deliv_max", deliv_w, 4'hF);
        w_if.in_valid = 1'b0;
        step();
        check("wrap_deliv_zero", deliv_w, 0);
        check("wrap_occ",        occ_w,   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
